mc_controller: RTL and testbench

Multi-cycle control FSM for the RV32I subset datapath. It sequences fetch, decode, execute, memory and writeback over a shared instruction/data memory port with a ready handshake. It drives every datapath mux and write enable, and selects the immediate format for the immediate generator. It also counts retired instructions and traps on illegal opcodes or a memory timeout.

---
 rtl/mc_ctrl_pkg.sv | 43 ++++
 rtl/mc_wait_timer.sv | 29 ++
 rtl/mc_controller.sv | 185 ++++++++++++++++++
 tb/tb_mc_controller.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_WB, ST_ADDR,
        ST_MEM_RD, ST_MEM_WR, ST_BRANCH, ST_JUMP, ST_TRAP
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
    } imm_type_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0, WB_MDR = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        TRAP_NONE = 2'd0, TRAP_ILLEGAL = 2'd1, TRAP_TIMEOUT = 2'd2, TRAP_BRANCH = 2'd3
    } trap_cause_e;

endpackage

// File: rtl/mc_wait_timer.sv
// Counts consecutive un-acknowledged memory wait cycles and flags the final allowed one.
module mc_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout_c
);
    localparam int unsigned CW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam int unsigned LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

    logic [CW-1:0] count;

    // A completed access or any non-memory state restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (!active || mem_ready) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign timeout_c = (MEM_TIMEOUT != 0) && active && !mem_ready && (count == CW'(LAST));

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback, counts retires, traps.
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_code,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        lt,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        mdr_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  wb_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  imm_type,
    output logic        retire,
    output logic [31:0] instret,
    output logic        halt,
    output logic [1:0]  trap_cause
);
    state_e      state_q, state_n;
    trap_cause_e cause_q, cause_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        taken;
    logic        wait_st;
    logic        timeout_c;
    logic        unused_inst;

    assign opcode      = inst_code[6:0];
    assign funct3      = inst_code[14:12];
    assign unused_inst = ^{inst_code[31:15], inst_code[11:7]};
    assign wait_st     = state_q inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR};
    assign trap_cause  = cause_q;

    mc_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .active    (wait_st),
        .mem_ready (mem_ready),
        .timeout_c (timeout_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cause_q <= TRAP_NONE;
            instret <= '0;
        end else begin
            state_q <= state_n;
            cause_q <= cause_n;
            if (retire) instret <= instret + 32'd1;
        end
    end

    always_comb begin
        state_n      = state_q;
        cause_n      = cause_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        reg_we       = 1'b0;
        pc_src       = PC_PLUS4;
        wb_sel       = WB_ALU;
        alu_src_b    = 1'b0;
        alu_op       = ALU_ADD;
        imm_type     = IMM_I;
        retire       = 1'b0;
        halt         = 1'b0;
        taken        = ((funct3 == F3_BEQ) &&  zero) || ((funct3 == F3_BNE) && !zero) ||
                       ((funct3 == F3_BLT) &&  lt)   || ((funct3 == F3_BGE) && !lt);

        case (state_q)
            ST_IDLE: state_n = ST_FETCH;
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    state_n = ST_DECODE;
                end else if (timeout_c) begin
                    state_n = ST_TRAP;
                    cause_n = TRAP_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OPC_OP, OPC_OP_IMM:   state_n = ST_EXEC;
                    OPC_LUI:              state_n = ST_WB;
                    OPC_LOAD, OPC_STORE:  state_n = ST_ADDR;
                    OPC_BRANCH:           state_n = ST_BRANCH;
                    OPC_JAL, OPC_JALR:    state_n = ST_JUMP;
                    default: begin
                        state_n = ST_TRAP;
                        cause_n = TRAP_ILLEGAL;
                    end
                endcase
            end
            ST_EXEC: begin
                alu_op    = ALU_FUNCT;
                alu_src_b = (opcode == OPC_OP_IMM);
                state_n   = ST_WB;
            end
            ST_WB: begin
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_n = ST_FETCH;
                if (opcode == OPC_LOAD) begin
                    wb_sel = WB_MDR;
                end else if (opcode == OPC_LUI) begin
                    wb_sel   = WB_IMM;
                    imm_type = IMM_U;
                end
            end
            ST_ADDR: begin
                alu_src_b = 1'b1;
                imm_type  = (opcode == OPC_STORE) ? IMM_S : IMM_I;
                state_n   = (opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD, ST_MEM_WR: begin
                // Address ALU controls stay up for the whole access.
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (state_q == ST_MEM_WR);
                alu_src_b    = 1'b1;
                imm_type     = (state_q == ST_MEM_WR) ? IMM_S : IMM_I;
                if (mem_ready) begin
                    if (state_q == ST_MEM_RD) begin
                        mdr_we  = 1'b1;
                        state_n = ST_WB;
                    end else begin
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_n = ST_FETCH;
                    end
                end else if (timeout_c) begin
                    state_n = ST_TRAP;
                    cause_n = TRAP_TIMEOUT;
                end
            end
            ST_BRANCH: begin
                alu_op   = ALU_SUB;
                imm_type = IMM_B;
                if (funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE}) begin
                    pc_we   = 1'b1;
                    retire  = 1'b1;
                    pc_src  = taken ? PC_IMM : PC_PLUS4;
                    state_n = ST_FETCH;
                end else begin
                    state_n = ST_TRAP;
                    cause_n = TRAP_BRANCH;
                end
            end
            ST_JUMP: begin
                reg_we  = 1'b1;
                wb_sel  = WB_PC4;
                pc_we   = 1'b1;
                retire  = 1'b1;
                state_n = ST_FETCH;
                if (opcode == OPC_JAL) begin
                    pc_src   = PC_IMM;
                    imm_type = IMM_J;
                end else begin
                    pc_src    = PC_ALU;
                    alu_src_b = 1'b1;
                end
            end
            ST_TRAP: halt = 1'b1;
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle control vectors against hand-computed values.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_code;
    logic        mem_ready;
    logic        zero;
    logic        lt;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, reg_we;
    logic [1:0]  pc_src, wb_sel, alu_op, trap_cause;
    logic        alu_src_b, retire, halt;
    logic [2:0]  imm_type;
    logic [31:0] instret;

    int n_checks = 0;
    int n_pass   = 0;

    mc_controller #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_code    (inst_code),
        .mem_ready    (mem_ready),
        .zero         (zero),
        .lt           (lt),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .mdr_we       (mdr_we),
        .pc_we        (pc_we),
        .reg_we       (reg_we),
        .pc_src       (pc_src),
        .wb_sel       (wb_sel),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .imm_type     (imm_type),
        .retire       (retire),
        .instret      (instret),
        .halt         (halt),
        .trap_cause   (trap_cause)
    );

    always #5 clk = ~clk;

    // Field masks for the packed control vector below.
    localparam logic [20:0] E_REQ     = 21'h100000;
    localparam logic [20:0] E_WE      = 21'h080000;
    localparam logic [20:0] E_ASEL    = 21'h040000;
    localparam logic [20:0] E_IR      = 21'h020000;
    localparam logic [20:0] E_MDR     = 21'h010000;
    localparam logic [20:0] E_PCWE    = 21'h008000;
    localparam logic [20:0] E_REGWE   = 21'h004000;
    localparam logic [20:0] E_PCS_IMM = 21'h001000;
    localparam logic [20:0] E_PCS_ALU = 21'h002000;
    localparam logic [20:0] E_WB_MDR  = 21'h000400;
    localparam logic [20:0] E_WB_PC4  = 21'h000800;
    localparam logic [20:0] E_WB_IMM  = 21'h000C00;
    localparam logic [20:0] E_SRCB    = 21'h000200;
    localparam logic [20:0] E_ALU_SUB = 21'h000080;
    localparam logic [20:0] E_ALU_FN  = 21'h000100;
    localparam logic [20:0] E_IMM_S   = 21'h000010;
    localparam logic [20:0] E_IMM_B   = 21'h000020;
    localparam logic [20:0] E_IMM_J   = 21'h000030;
    localparam logic [20:0] E_IMM_U   = 21'h000040;
    localparam logic [20:0] E_RET     = 21'h000008;
    localparam logic [20:0] E_HALT    = 21'h000004;
    localparam logic [20:0] E_C_ILL   = 21'h000001;
    localparam logic [20:0] E_C_TO    = 21'h000002;
    localparam logic [20:0] E_C_BR    = 21'h000003;
    localparam logic [20:0] E_NONE    = 21'h000000;

    logic [20:0] obs;
    assign obs = {mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we, reg_we, pc_src,
                  wb_sel, alu_src_b, alu_op, imm_type, retire, halt, trap_cause};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Entered and left at posedge+1: drive mem_ready, sample mid-cycle, advance one clock.
    task automatic cyc(input string tag, input logic rdy, input logic [20:0] e);
        mem_ready = rdy;
        #1;
        check(tag, 32'(obs), 32'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_decode(input string tag, input logic [31:0] ins);
        inst_code = ins;
        cyc({tag, "_fetch"}, 1'b1, E_REQ | E_IR);
        cyc({tag, "_decode"}, 1'b1, E_NONE);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1;
        #1;
        check({tag, "_outs"}, 32'(obs), 32'd0);
        check({tag, "_instret"}, instret, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc({tag, "_idle"}, 1'b1, E_NONE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        inst_code = 32'h0;
        mem_ready = 1'b0;
        zero = 1'b0;
        lt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 32'(obs), 32'd0);
        check("reset_instret", instret, 32'd0);
        reset = 1'b0;
        cyc("idle", 1'b0, E_NONE);

        // R-type add
        fetch_decode("add", 32'h002081B3);
        cyc("add_exec", 1'b1, E_ALU_FN);
        check("add_instret_pre", instret, 32'd0);
        cyc("add_wb", 1'b1, E_REGWE | E_PCWE | E_RET);
        check("add_instret", instret, 32'd1);

        // lw with three wait cycles
        fetch_decode("lw", 32'h0000A103);
        cyc("lw_addr", 1'b1, E_SRCB);
        for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 1'b0, E_REQ | E_ASEL | E_SRCB);
        cyc("lw_memrd_done", 1'b1, E_REQ | E_ASEL | E_SRCB | E_MDR);
        cyc("lw_wb", 1'b1, E_REGWE | E_WB_MDR | E_PCWE | E_RET);
        check("lw_instret", instret, 32'd2);

        // sw
        fetch_decode("sw", 32'h0020A023);
        cyc("sw_addr", 1'b1, E_SRCB | E_IMM_S);
        cyc("sw_memwr", 1'b1, E_REQ | E_WE | E_ASEL | E_SRCB | E_IMM_S | E_PCWE | E_RET);
        check("sw_instret", instret, 32'd3);

        // beq taken / not taken, blt taken, bge not taken
        zero = 1'b1;
        fetch_decode("beq_t", 32'h00208463);
        cyc("beq_taken", 1'b1, E_ALU_SUB | E_IMM_B | E_PCWE | E_RET | E_PCS_IMM);
        zero = 1'b0;
        fetch_decode("beq_n", 32'h00208463);
        cyc("beq_not_taken", 1'b1, E_ALU_SUB | E_IMM_B | E_PCWE | E_RET);
        check("beq_instret", instret, 32'd5);
        lt = 1'b1;
        fetch_decode("blt", 32'h0020C463);
        cyc("blt_taken", 1'b1, E_ALU_SUB | E_IMM_B | E_PCWE | E_RET | E_PCS_IMM);
        fetch_decode("bge", 32'h0020D463);
        cyc("bge_not_taken", 1'b1, E_ALU_SUB | E_IMM_B | E_PCWE | E_RET);
        lt = 1'b0;

        // jal, jalr, lui, addi
        fetch_decode("jal", 32'h008000EF);
        cyc("jal_jump", 1'b1, E_REGWE | E_WB_PC4 | E_PCWE | E_RET | E_PCS_IMM | E_IMM_J);
        fetch_decode("jalr", 32'h000080E7);
        cyc("jalr_jump", 1'b1, E_REGWE | E_WB_PC4 | E_PCWE | E_RET | E_PCS_ALU | E_SRCB);
        fetch_decode("lui", 32'h123450B7);
        cyc("lui_wb", 1'b1, E_REGWE | E_WB_IMM | E_IMM_U | E_PCWE | E_RET);
        fetch_decode("addi", 32'h00108093);
        cyc("addi_exec", 1'b1, E_ALU_FN | E_SRCB);
        cyc("addi_wb", 1'b1, E_REGWE | E_PCWE | E_RET);
        check("mix_instret", instret, 32'd11);

        // unsupported branch funct3
        fetch_decode("bbad", 32'h0020A463);
        cyc("bbad_branch", 1'b1, E_ALU_SUB | E_IMM_B);
        cyc("bbad_trap", 1'b1, E_HALT | E_C_BR);
        check("bbad_instret", instret, 32'd11);
        apply_reset("rst1");

        // illegal opcode
        fetch_decode("ill", 32'hFFFFFFFF);
        for (int i = 0; i < 3; i++) cyc("ill_trap", 1'b1, E_HALT | E_C_ILL);
        apply_reset("rst2");

        // fetch timeout after four unanswered cycles
        for (int i = 0; i < 4; i++) cyc("to_fetch_wait", 1'b0, E_REQ);
        cyc("to_trap", 1'b1, E_HALT | E_C_TO);
        cyc("to_trap_hold", 1'b0, E_HALT | E_C_TO);
        apply_reset("rst3");

        // ready on the last allowed cycle wins
        inst_code = 32'h00108093;
        for (int i = 0; i < 3; i++) cyc("late_fetch_wait", 1'b0, E_REQ);
        cyc("late_fetch_done", 1'b1, E_REQ | E_IR);
        cyc("late_decode", 1'b1, E_NONE);
        cyc("late_exec", 1'b1, E_ALU_FN | E_SRCB);
        cyc("late_wb", 1'b1, E_REGWE | E_PCWE | E_RET);
        check("late_instret", instret, 32'd1);

        // reset in the middle of a store access
        fetch_decode("swr", 32'h0020A023);
        cyc("swr_addr", 1'b1, E_SRCB | E_IMM_S);
        mem_ready = 1'b0;
        #1;
        check("swr_memwr", 32'(obs), 32'(E_REQ | E_WE | E_ASEL | E_SRCB | E_IMM_S));
        reset = 1'b1;
        #1;
        check("swr_rst_req_we", 32'({mem_req, mem_we}), 32'd0);
        check("swr_rst_outs", 32'(obs), 32'd0);
        check("swr_rst_instret", instret, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc("swr_idle", 1'b1, E_NONE);
        cyc("swr_refetch", 1'b1, E_REQ | E_IR);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
